// File: rtl/raw10_packer_pkg.sv
// Shared constants, FSM encoding and pixel expansion helper for the RAW8 -> CSI RAW10 packer.
package raw10_packer_pkg;

    localparam int GroupWidth = 40;
    localparam int GroupBytes = 5;
    localparam int BufDepth   = 12;
    localparam int CountWidth = 4;

    typedef enum logic [1:0] {
        StRun,
        StFlush,
        StEnd
    } state_e;

    // 8-bit pixel to 10-bit with black level restored; 11-bit sum cannot wrap.
    function automatic logic [9:0] expand_pix(input logic [7:0] raw, input logic [9:0] black);
        logic [10:0] sum;
        sum = {1'b0, raw, 2'b00} + {1'b0, black};
        return sum[10] ? 10'h3ff : sum[9:0];
    endfunction

endpackage

// File: rtl/raw10_expand.sv
// Expands one 4-pixel RAW8 group to 10-bit and orders it as five CSI RAW10 bytes (first byte in MSBs).
module raw10_expand
    import raw10_packer_pkg::*;
(
    input  logic [31:0]           I_raw_data,
    input  logic [9:0]            I_black_level,
    output logic [GroupWidth-1:0] O_group_bytes
);

    logic [9:0] pix [4];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            pix[k] = expand_pix(I_raw_data[31-8*k -: 8], I_black_level);
        end
    end

    assign O_group_bytes = {pix[0][9:2], pix[1][9:2], pix[2][9:2], pix[3][9:2],
                            pix[3][1:0], pix[2][1:0], pix[1][1:0], pix[0][1:0]};

endmodule

// File: rtl/raw10_packer.sv
// RAW8 group to CSI RAW10 word packer: 12-byte FIFO byte buffer, line flush padding, frame framing.
module raw10_packer
    import raw10_packer_pkg::*;
#(
    parameter logic [7:0] P_PAD_BYTE = 8'h00
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_raw8_frame_start,
    input  logic        I_raw8_frame_end,
    input  logic        I_raw8_valid,
    output logic        O_raw8_ready,
    input  logic [31:0] I_raw8_data,
    input  logic        I_raw8_line_end,
    input  logic [9:0]  I_camera_black_level,
    output logic        O_csi_frame_start,
    output logic        O_csi_frame_end,
    output logic        O_csi_valid,
    input  logic        I_csi_ready,
    output logic [31:0] O_csi_data
);

    state_e                state_q, state_d;
    logic [7:0]            buf_q [BufDepth];
    logic [7:0]            buf_d [BufDepth];
    logic [CountWidth-1:0] count_q, count_d;
    logic [31:0]           csi_data_q, csi_data_d;
    logic                  csi_valid_q, csi_valid_d;
    logic                  frame_start_q;
    logic                  frame_end_q, frame_end_d;
    logic [GroupWidth-1:0] group_bytes;
    logic                  accept, out_free, word_load, pad_load;
    int                    shift, keep;

    raw10_expand u_expand (
        .I_raw_data    (I_raw8_data),
        .I_black_level (I_camera_black_level),
        .O_group_bytes (group_bytes)
    );

    assign O_raw8_ready = (count_q <= CountWidth'(7)) && (state_q == StRun);
    assign accept       = I_raw8_valid && O_raw8_ready;
    assign out_free     = !csi_valid_q || I_csi_ready;
    assign word_load    = (count_q >= CountWidth'(4)) && out_free;
    // A short tail is only padded out once the line or frame has been closed.
    assign pad_load     = (state_q != StRun) && (count_q != '0) &&
                          (count_q < CountWidth'(4)) && out_free;

    always_comb begin
        shift = word_load ? 4 : (pad_load ? int'(count_q) : 0);
        keep  = int'(count_q) - shift;
        for (int i = 0; i < BufDepth; i++) begin
            buf_d[i] = (i + shift < BufDepth) ? buf_q[i + shift] : 8'h00;
            if (accept && (i >= keep) && (i < keep + GroupBytes)) begin
                buf_d[i] = group_bytes[8*(GroupBytes-1-(i-keep)) +: 8];
            end
        end
        count_d = CountWidth'(keep + (accept ? GroupBytes : 0));
        if (I_raw8_frame_start) begin
            for (int i = 0; i < BufDepth; i++) begin
                buf_d[i] = 8'h00;
            end
            count_d = '0;
        end
    end

    always_comb begin
        csi_data_d  = csi_data_q;
        csi_valid_d = csi_valid_q && !I_csi_ready;
        if (word_load) begin
            csi_data_d  = {buf_q[0], buf_q[1], buf_q[2], buf_q[3]};
            csi_valid_d = 1'b1;
        end else if (pad_load) begin
            for (int j = 0; j < 4; j++) begin
                csi_data_d[31-8*j -: 8] = (j < int'(count_q)) ? buf_q[j] : P_PAD_BYTE;
            end
            csi_valid_d = 1'b1;
        end
        if (I_raw8_frame_start) begin
            csi_data_d  = '0;
            csi_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_end_d = 1'b0;
        unique case (state_q)
            StRun: begin
                if (I_raw8_frame_end) begin
                    state_d = StEnd;
                end else if (accept && I_raw8_line_end) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (I_raw8_frame_end) begin
                    state_d = StEnd;
                end else if (count_q == '0) begin
                    state_d = StRun;
                end
            end
            StEnd: begin
                // Last word leaves the output register this cycle (or it is already empty).
                if ((count_q == '0) && out_free) begin
                    state_d     = StRun;
                    frame_end_d = 1'b1;
                end
            end
            default: state_d = StRun;
        endcase
        if (I_raw8_frame_start) begin
            state_d     = StRun;
            frame_end_d = 1'b0;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q       <= StRun;
            count_q       <= '0;
            csi_data_q    <= '0;
            csi_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            for (int i = 0; i < BufDepth; i++) begin
                buf_q[i] <= 8'h00;
            end
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            csi_data_q    <= csi_data_d;
            csi_valid_q   <= csi_valid_d;
            frame_start_q <= I_raw8_frame_start;
            frame_end_q   <= frame_end_d;
            for (int i = 0; i < BufDepth; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    assign O_csi_data        = csi_data_q;
    assign O_csi_valid       = csi_valid_q;
    assign O_csi_frame_start = frame_start_q;
    assign O_csi_frame_end   = frame_end_q;

endmodule

// File: tb/tb_raw10_packer.sv
// Self-checking bench for raw10_packer: directed cases plus randomized traffic against a byte-stream model.
module tb_raw10_packer;

    localparam logic [7:0] PAD = 8'h00;

    logic        I_clk;
    logic        I_rst_n;
    logic        I_raw8_frame_start;
    logic        I_raw8_frame_end;
    logic        I_raw8_valid;
    logic        O_raw8_ready;
    logic [31:0] I_raw8_data;
    logic        I_raw8_line_end;
    logic [9:0]  I_camera_black_level;
    logic        O_csi_frame_start;
    logic        O_csi_frame_end;
    logic        O_csi_valid;
    logic        I_csi_ready;
    logic [31:0] O_csi_data;

    int          total;
    int          bad;
    logic [31:0] got_q [$];
    logic [7:0]  exp_b [$];
    int          fe_cnt;
    int          fe_words;
    logic [31:0] basic_w [5] = '{32'h12345678, 32'h00123456, 32'h78001234,
                                 32'h56780012, 32'h34567800};

    raw10_packer #(
        .P_PAD_BYTE (PAD)
    ) dut (
        .I_clk                (I_clk),
        .I_rst_n              (I_rst_n),
        .I_raw8_frame_start   (I_raw8_frame_start),
        .I_raw8_frame_end     (I_raw8_frame_end),
        .I_raw8_valid         (I_raw8_valid),
        .O_raw8_ready         (O_raw8_ready),
        .I_raw8_data          (I_raw8_data),
        .I_raw8_line_end      (I_raw8_line_end),
        .I_camera_black_level (I_camera_black_level),
        .O_csi_frame_start    (O_csi_frame_start),
        .O_csi_frame_end      (O_csi_frame_end),
        .O_csi_valid          (O_csi_valid),
        .I_csi_ready          (I_csi_ready),
        .O_csi_data           (O_csi_data)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    // Inputs change just after the rising edge, so the falling edge sees what the next edge will use.
    always @(negedge I_clk) begin
        if (I_rst_n && O_csi_valid && I_csi_ready) got_q.push_back(O_csi_data);
        if (O_csi_frame_end) begin
            fe_cnt++;
            fe_words = got_q.size();
        end
    end

    task automatic step();
        @(posedge I_clk);
        #1;
    endtask

    task automatic drain(input int n);
        repeat (n) step();
    endtask

    task automatic clear_sb();
        got_q.delete();
        exp_b.delete();
        fe_cnt   = 0;
        fe_words = 0;
    endtask

    // Reference: each pixel is raw*4 + black clipped to 1023; four high bytes then the packed LSBs.
    function automatic void model_group(input logic [31:0] raw, input logic [9:0] blk);
        int pix [4];
        int lowb;
        for (int k = 0; k < 4; k++) begin
            pix[k] = int'(raw[31-8*k -: 8]) * 4 + int'(blk);
            if (pix[k] > 1023) pix[k] = 1023;
            exp_b.push_back(8'(pix[k] / 4));
        end
        lowb = (pix[3] % 4) * 64 + (pix[2] % 4) * 16 + (pix[1] % 4) * 4 + (pix[0] % 4);
        exp_b.push_back(8'(lowb));
    endfunction

    function automatic void model_pad();
        while (exp_b.size() % 4 != 0) exp_b.push_back(PAD);
    endfunction

    task automatic send_group(input logic [31:0] d, input logic le, output bit ok);
        ok              = 1'b0;
        I_raw8_valid    = 1'b1;
        I_raw8_data     = d;
        I_raw8_line_end = le;
        for (int n = 0; n < 500; n++) begin
            if (O_raw8_ready) begin
                ok = 1'b1;
                model_group(d, I_camera_black_level);
                if (le) model_pad();
                step();
                break;
            end
            step();
        end
        I_raw8_valid    = 1'b0;
        I_raw8_line_end = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout got=ready_low want=accept data=%h", d);
        end
    endtask

    task automatic pulse_frame_start();
        I_raw8_frame_start = 1'b1;
        step();
        I_raw8_frame_start = 1'b0;
    endtask

    task automatic test_reset();
        I_rst_n = 1'b0;
        #12;
        total++; if (O_csi_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", O_csi_valid); end
        total++; if (O_csi_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h want=0", O_csi_data); end
        total++; if (O_csi_frame_start !== 1'b0) begin bad++; $display("FAIL rst_fs got=%b want=0", O_csi_frame_start); end
        total++; if (O_csi_frame_end !== 1'b0) begin bad++; $display("FAIL rst_fe got=%b want=0", O_csi_frame_end); end
        step();
        I_rst_n = 1'b1;
        step();
        total++; if (O_raw8_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", O_raw8_ready); end
        total++; if (O_csi_valid !== 1'b0) begin bad++; $display("FAIL rst_valid_after got=%b want=0", O_csi_valid); end
    endtask

    task automatic test_basic();
        bit ok;
        clear_sb();
        I_camera_black_level = 10'd0;
        I_csi_ready          = 1'b1;
        pulse_frame_start();
        total++; if (O_csi_frame_start !== 1'b1) begin bad++; $display("FAIL fs_pulse got=%b want=1", O_csi_frame_start); end
        step();
        total++; if (O_csi_frame_start !== 1'b0) begin bad++; $display("FAIL fs_single got=%b want=0", O_csi_frame_start); end
        send_group(32'h12345678, 1'b0, ok);
        total++; if (O_csi_valid !== 1'b0) begin bad++; $display("FAIL latency_early got=%b want=0", O_csi_valid); end
        step();
        total++; if (O_csi_valid !== 1'b1) begin bad++; $display("FAIL latency_t2 got=%b want=1", O_csi_valid); end
        for (int i = 0; i < 3; i++) send_group(32'h12345678, 1'b0, ok);
        drain(20);
        total++; if (got_q.size() != 5) begin bad++; $display("FAIL basic_count got=%0d want=5", got_q.size()); end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== basic_w[i]) begin
                bad++;
                $display("FAIL basic_word%0d got=%h want=%h", i, got_q[i], basic_w[i]);
            end
        end
    endtask

    task automatic test_line_end();
        bit ok;
        clear_sb();
        I_camera_black_level = 10'h001;
        send_group(32'h12345678, 1'b1, ok);
        total++; if (O_raw8_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b want=0", O_raw8_ready); end
        drain(20);
        total++; if (got_q.size() != 2) begin bad++; $display("FAIL flush_count got=%0d want=2", got_q.size()); end
        if (got_q.size() >= 2) begin
            total++; if (got_q[0] !== 32'h12345678) begin bad++; $display("FAIL flush_w0 got=%h want=12345678", got_q[0]); end
            total++; if (got_q[1] !== 32'h55000000) begin bad++; $display("FAIL flush_pad got=%h want=55000000", got_q[1]); end
        end
        total++; if (O_raw8_ready !== 1'b1) begin bad++; $display("FAIL flush_ready_back got=%b want=1", O_raw8_ready); end
    endtask

    task automatic test_saturation();
        bit ok;
        clear_sb();
        I_camera_black_level = 10'h040;
        send_group(32'hffffffff, 1'b1, ok);
        drain(20);
        total++; if (got_q.size() != 2) begin bad++; $display("FAIL sat_count got=%0d want=2", got_q.size()); end
        if (got_q.size() >= 2) begin
            total++; if (got_q[0] !== 32'hffffffff) begin bad++; $display("FAIL sat_w0 got=%h want=ffffffff", got_q[0]); end
            total++; if (got_q[1] !== 32'hff000000) begin bad++; $display("FAIL sat_w1 got=%h want=ff000000", got_q[1]); end
        end
    endtask

    task automatic test_stall();
        bit          ok;
        bit          saw_low;
        logic [31:0] hold;
        logic [31:0] exp_w;
        clear_sb();
        I_camera_black_level = 10'($urandom_range(0, 1023));
        I_csi_ready          = 1'b1;
        saw_low              = 1'b0;
        pulse_frame_start();
        fork
            begin
                for (int i = 0; i < 8; i++) send_group($urandom, (i == 7), ok);
            end
            begin
                for (int n = 0; n < 100 && !O_csi_valid; n++) step();
                I_csi_ready = 1'b0;
                hold        = O_csi_data;
                repeat (10) begin
                    step();
                    if (!O_raw8_ready) saw_low = 1'b1;
                    total++;
                    if (O_csi_data !== hold || O_csi_valid !== 1'b1) begin
                        bad++;
                        $display("FAIL stall_hold got=%h/%b want=%h/1", O_csi_data, O_csi_valid, hold);
                    end
                end
                I_csi_ready = 1'b1;
            end
        join
        drain(60);
        total++; if (saw_low !== 1'b1) begin bad++; $display("FAIL stall_backpressure got=%b want=1", saw_low); end
        total++;
        if (got_q.size() != exp_b.size() / 4) begin
            bad++;
            $display("FAIL stall_count got=%0d want=%0d", got_q.size(), exp_b.size() / 4);
        end
        for (int i = 0; i < got_q.size() && 4 * i + 3 < exp_b.size(); i++) begin
            exp_w = {exp_b[4*i], exp_b[4*i+1], exp_b[4*i+2], exp_b[4*i+3]};
            total++;
            if (got_q[i] !== exp_w) begin bad++; $display("FAIL stall_word%0d got=%h want=%h", i, got_q[i], exp_w); end
        end
    endtask

    task automatic test_frame_end();
        bit          ok;
        logic [31:0] exp_w;
        clear_sb();
        I_camera_black_level = 10'($urandom_range(0, 1023));
        I_csi_ready          = 1'b0;
        pulse_frame_start();
        send_group($urandom, 1'b0, ok);
        send_group($urandom, 1'b0, ok);
        I_raw8_frame_end = 1'b1;
        step();
        I_raw8_frame_end = 1'b0;
        model_pad();
        total++; if (O_raw8_ready !== 1'b0) begin bad++; $display("FAIL end_ready got=%b want=0", O_raw8_ready); end
        I_csi_ready = 1'b1;
        drain(30);
        total++; if (got_q.size() != 3) begin bad++; $display("FAIL end_count got=%0d want=3", got_q.size()); end
        for (int i = 0; i < got_q.size() && 4 * i + 3 < exp_b.size(); i++) begin
            exp_w = {exp_b[4*i], exp_b[4*i+1], exp_b[4*i+2], exp_b[4*i+3]};
            total++;
            if (got_q[i] !== exp_w) begin bad++; $display("FAIL end_word%0d got=%h want=%h", i, got_q[i], exp_w); end
        end
        total++; if (fe_cnt != 1) begin bad++; $display("FAIL end_fe_pulses got=%0d want=1", fe_cnt); end
        total++; if (fe_words != 3) begin bad++; $display("FAIL end_fe_after got=%0d want=3", fe_words); end
        total++; if (O_raw8_ready !== 1'b1) begin bad++; $display("FAIL end_ready_back got=%b want=1", O_raw8_ready); end
    endtask

    task automatic test_random();
        bit          ok;
        bit          done;
        logic [31:0] exp_w;
        clear_sb();
        I_camera_black_level = 10'($urandom_range(0, 1023));
        done                 = 1'b0;
        pulse_frame_start();
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    drain($urandom_range(0, 2));
                    send_group($urandom, (i == 23) || ($urandom_range(0, 4) == 0), ok);
                end
                done = 1'b1;
            end
            begin
                for (int n = 0; n < 5000 && !done; n++) begin
                    I_csi_ready = 1'($urandom_range(0, 1));
                    step();
                end
                I_csi_ready = 1'b1;
            end
        join
        drain(60);
        total++;
        if (got_q.size() != exp_b.size() / 4) begin
            bad++;
            $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_b.size() / 4);
        end
        for (int i = 0; i < got_q.size() && 4 * i + 3 < exp_b.size(); i++) begin
            exp_w = {exp_b[4*i], exp_b[4*i+1], exp_b[4*i+2], exp_b[4*i+3]};
            total++;
            if (got_q[i] !== exp_w) begin bad++; $display("FAIL rand_word%0d got=%h want=%h", i, got_q[i], exp_w); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_sb();
        I_camera_black_level = 10'h155;
        I_csi_ready          = 1'b0;
        pulse_frame_start();
        send_group(32'hdeadbeef, 1'b0, ok);
        send_group(32'hcafef00d, 1'b0, ok);
        I_rst_n = 1'b0;
        #1;
        total++; if (O_csi_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", O_csi_valid); end
        total++; if (O_csi_data !== 32'h0) begin bad++; $display("FAIL midrst_data got=%h want=0", O_csi_data); end
        total++; if (O_csi_frame_end !== 1'b0) begin bad++; $display("FAIL midrst_fe got=%b want=0", O_csi_frame_end); end
        step();
        step();
        I_rst_n     = 1'b1;
        I_csi_ready = 1'b1;
        step();
        total++; if (O_raw8_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", O_raw8_ready); end
        drain(10);
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL midrst_stale got=%0d want=0", got_q.size()); end
        test_basic();
    endtask

    initial begin
        total                = 0;
        bad                  = 0;
        fe_cnt               = 0;
        fe_words             = 0;
        I_rst_n              = 1'b0;
        I_raw8_frame_start   = 1'b0;
        I_raw8_frame_end     = 1'b0;
        I_raw8_valid         = 1'b0;
        I_raw8_data          = 32'h0;
        I_raw8_line_end      = 1'b0;
        I_camera_black_level = 10'd0;
        I_csi_ready          = 1'b1;
        test_reset();
        test_basic();
        test_line_end();
        test_saturation();
        test_stall();
        test_frame_end();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/raw10_packer.md
RAW10_PACKER -- requirements
Module: raw10_packer

Interface
REQ-001 P_PAD_BYTE, 8'h00, fill byte used to complete a partial word at line end.
REQ-002 I_clk  input  1  single clock; all logic synchronous to its rising edge.
REQ-003 I_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 I_raw8_frame_start / I_raw8_frame_end  input  1 each  single-cycle frame pulses.
REQ-005 I_raw8_valid  input  1  a 4-pixel group is offered.
REQ-006 O_raw8_ready  output  1  group accepted when I_raw8_valid && O_raw8_ready.
REQ-007 I_raw8_data  input  32  P0=[31:24], P1=[23:16], P2=[15:8], P3=[7:0].
REQ-008 I_raw8_line_end  input  1  qualifies the accepted group as the last group of a line.
REQ-009 I_camera_black_level  input  10  black level added back to each pixel; quasi-static.
REQ-010 O_csi_frame_start / O_csi_frame_end  output  1 each  frame pulses aligned to the output stream.
REQ-011 O_csi_valid  output  1 / I_csi_ready  input  1  output handshake; transfer when both high.
REQ-012 O_csi_data  output  32  packed CSI RAW10 word; first stream byte in [31:24].

Function
REQ-013 Expansion: pix10 = (raw8 << 2) + I_camera_black_level, computed 11-bit, saturated to 1023.
REQ-014 Each accepted group appends 5 bytes in this order: P0[9:2], P1[9:2], P2[9:2], P3[9:2], {P3[1:0],P2[1:0],P1[1:0],P0[1:0]}.
REQ-015 Byte buffer: 12 bytes, FIFO order, byte count 0..12.
REQ-016 O_raw8_ready = (count <= 7) && no flush pending; this is the only backpressure path, and it is combinational from registers.
REQ-017 Output register loads the oldest 4 bytes when count >= 4 and (!O_csi_valid || I_csi_ready).
REQ-018 O_csi_data/O_csi_valid hold stable while O_csi_valid && !I_csi_ready.
REQ-019 Latency: a group accepted in cycle t gives O_csi_valid high from cycle t+2 (empty buffer, I_csi_ready high).
REQ-020 Simultaneous append and output load in one cycle: count' = count + 5 - 4.
REQ-021 FSM states: RUN, FLUSH, END.
REQ-022 RUN -> FLUSH when a line_end group is accepted; FLUSH blocks input.
REQ-023 FLUSH: once count is 1..3, emit one word with the remaining bytes in the high positions, padded with P_PAD_BYTE.
REQ-024 FLUSH -> RUN when count reaches 0; no pad word is emitted if count is already 0.
REQ-025 I_raw8_frame_end: RUN -> END; in END, O_raw8_ready = 0.
REQ-026 END: after the buffer is empty and the last word is transferred, pulse O_csi_frame_end for 1 cycle, then go to RUN.
REQ-027 I_raw8_frame_start clears buffer, count and the output register, forces RUN, and pulses O_csi_frame_start 1 cycle later.
REQ-028 frame_start takes priority over every other event in the same cycle.

Reset
REQ-029 Asynchronous reset: count=0, state=RUN, O_csi_valid=0, O_csi_data=0, O_csi_frame_start=0, O_csi_frame_end=0, O_raw8_ready=1 after release.
REQ-030 Reset mid-line discards all buffered bytes; no partial word is emitted afterwards.

Structure
REQ-031 Shared package: RAW10 group width 40, bytes per group 5, buffer depth 12, FSM state encoding.
REQ-032 One sub-module raw10_expand: combinational 4-pixel black-level add with saturation and 5-byte ordering.
REQ-033 All other logic is in raw10_packer; no vendor FIFO.

Verification
REQ-034 4 groups 0x12345678, black 0, I_csi_ready=1 -> words 0x12345678, 0x00123456, 0x78001234, 0x56780012, 0x34567800.
REQ-035 1 group 0x12345678 with line_end, black 0x001 -> words 0x12345678 then 0x55000000; ready low until done.
REQ-036 Group 0xFFFFFFFF, black 0x040 -> stream bytes FF FF FF FF FF (saturation).
REQ-037 I_csi_ready held low 10 cycles during continuous input -> ready drops at count>7, no byte loss or duplication, O_csi_data stable while stalled.
REQ-038 frame_end with 6 bytes buffered -> words drain (pad per flush rules), then a single O_csi_frame_end pulse.
REQ-039 Reset asserted mid-frame -> outputs zero immediately; after release, a fresh frame reproduces REQ-034 exactly.
